// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory drive, MEM/WB register,
// forwarding/hazard outputs and retired LOAD/STORE counters.
module mem_stage #(
    parameter int DW = 16,
    parameter int AW = 8,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          ex_valid,
    input  logic [1:0]    ex_op,
    input  logic [RW-1:0] ex_rd,
    input  logic [DW-1:0] ex_result,
    input  logic [DW-1:0] ex_sdata,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    output logic          dm_we,
    input  logic [DW-1:0] dm_rdata,
    output logic          fwd_valid,
    output logic [RW-1:0] fwd_rd,
    output logic [DW-1:0] fwd_data,
    output logic          load_use,
    output logic          wb_valid,
    output logic [RW-1:0] wb_rd,
    output logic [DW-1:0] wb_data,
    output logic [15:0]   load_cnt,
    output logic [15:0]   store_cnt
);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    logic          mem_valid_reg;
    logic [1:0]    mem_op_reg;
    logic [RW-1:0] mem_rd_reg;
    logic [DW-1:0] mem_result_reg;
    logic [DW-1:0] mem_sdata_reg;
    logic          store_done_reg;
    logic          wb_valid_reg;
    logic [RW-1:0] wb_rd_reg;
    logic [DW-1:0] wb_data_reg;

    logic          advance;
    logic          is_load;
    logic          is_store;
    logic          writes_reg;
    logic [DW-1:0] result_mux;
    logic [1:0]    cnt_hit;

    always_comb begin
        advance    = !stall;
        is_load    = mem_valid_reg && (mem_op_reg == OP_LOAD);
        is_store   = mem_valid_reg && (mem_op_reg == OP_STORE);
        writes_reg = mem_valid_reg && ((mem_op_reg == OP_ALU) || (mem_op_reg == OP_LOAD));
        result_mux = (mem_op_reg == OP_LOAD) ? dm_rdata : mem_result_reg;
        cnt_hit    = {is_store, is_load};
    end

    // Address and write data are forced to zero for an empty slot so the bus stays quiet.
    assign dm_addr   = mem_valid_reg ? mem_result_reg[AW-1:0] : '0;
    assign dm_wdata  = mem_valid_reg ? mem_sdata_reg : '0;
    assign dm_we     = is_store && !store_done_reg;
    assign fwd_valid = writes_reg;
    assign fwd_rd    = mem_rd_reg;
    assign fwd_data  = result_mux;
    assign load_use  = is_load;
    assign wb_valid  = wb_valid_reg;
    assign wb_rd     = wb_rd_reg;
    assign wb_data   = wb_data_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid_reg  <= 1'b0;
            mem_op_reg     <= OP_NOP;
            mem_rd_reg     <= '0;
            mem_result_reg <= '0;
            mem_sdata_reg  <= '0;
        end else if (advance) begin
            mem_valid_reg  <= ex_valid && (ex_op != OP_NOP);
            mem_op_reg     <= ex_op;
            mem_rd_reg     <= ex_rd;
            mem_result_reg <= ex_result;
            mem_sdata_reg  <= ex_sdata;
        end
    end

    // A stalled store writes on its first cycle only; the flag clears when the entry moves on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            store_done_reg <= 1'b0;
        end else if (advance) begin
            store_done_reg <= 1'b0;
        end else if (dm_we) begin
            store_done_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_reg <= 1'b0;
            wb_rd_reg    <= '0;
            wb_data_reg  <= '0;
        end else if (advance) begin
            wb_valid_reg <= writes_reg;
            wb_rd_reg    <= mem_rd_reg;
            wb_data_reg  <= result_mux;
        end
    end

    // Index 0 counts loads, index 1 counts stores; both wrap naturally at 16 bits.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [15:0] cnt_reg;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_reg <= '0;
            end else if (advance && cnt_hit[gi]) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
    end

    assign load_cnt  = g_cnt[0].cnt_reg;
    assign store_cnt = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// compared against a transaction-level model of the stage and its data memory.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        ex_valid = 1'b0;
    logic [1:0]  ex_op = 2'b00;
    logic [2:0]  ex_rd = 3'd0;
    logic [15:0] ex_result = 16'd0;
    logic [15:0] ex_sdata = 16'd0;
    logic [7:0]  dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_we;
    logic [15:0] dm_rdata;
    logic        fwd_valid;
    logic [2:0]  fwd_rd;
    logic [15:0] fwd_data;
    logic        load_use;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [15:0] load_cnt;
    logic [15:0] store_cnt;

    always #5 clk = ~clk;

    mem_stage #(.DW(16), .AW(8), .RW(3)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd),
        .ex_result(ex_result), .ex_sdata(ex_sdata),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .load_use(load_use),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .load_cnt(load_cnt), .store_cnt(store_cnt)
    );

    // Data memory with a preload port used while the stage is held in reset.
    logic [15:0] tb_mem [256];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = 8'd0;
    logic [15:0] pre_data = 16'd0;
    always @(posedge clk) begin
        if (pre_we) tb_mem[pre_addr] <= pre_data;
        else if (dm_we) tb_mem[dm_addr] <= dm_wdata;
    end
    assign dm_rdata = tb_mem[dm_addr];

    // Transaction-level model: the instruction in MEM, the retired write-back, memory image.
    logic        m_valid;
    logic [1:0]  m_op;
    logic [2:0]  m_rd;
    logic [15:0] m_res, m_sd;
    logic        m_written;
    logic        w_valid;
    logic [2:0]  w_rd;
    logic [15:0] w_data;
    logic [15:0] m_lc, m_sc;
    logic [15:0] ref_mem [256];
    int          we_seen;
    int          checks = 0;
    int          failures = 0;

    function automatic logic exp_we();
        return m_valid && (m_op == 2'b11) && !m_written;
    endfunction
    function automatic logic [7:0] exp_addr();
        return m_valid ? m_res[7:0] : 8'h00;
    endfunction
    function automatic logic [15:0] exp_wdata();
        return m_valid ? m_sd : 16'h0000;
    endfunction
    function automatic logic exp_fwd();
        return m_valid && ((m_op == 2'b01) || (m_op == 2'b10));
    endfunction
    function automatic logic [15:0] exp_fdata();
        return (m_op == 2'b10) ? ref_mem[m_res[7:0]] : m_res;
    endfunction

    task automatic model_clear();
        m_valid = 1'b0; m_op = 2'b00; m_rd = 3'd0; m_res = 16'd0; m_sd = 16'd0;
        m_written = 1'b0; w_valid = 1'b0; w_rd = 3'd0; w_data = 16'd0;
        m_lc = 16'd0; m_sc = 16'd0;
    endtask

    // Drive one cycle (from a negedge), advance the model at the edge, return at negedge+1.
    task automatic cycle(input logic v, input logic [1:0] op, input logic [2:0] rd,
                         input logic [15:0] res, input logic [15:0] sd, input logic st);
        logic we_e, fwd_e;
        logic [7:0] a_e;
        logic [15:0] fd_e;
        ex_valid = v; ex_op = op; ex_rd = rd; ex_result = res; ex_sdata = sd; stall = st;
        we_e = exp_we(); a_e = exp_addr(); fwd_e = exp_fwd(); fd_e = exp_fdata();
        if (dm_we === 1'b1) we_seen++;
        @(posedge clk);
        if (we_e) ref_mem[a_e] = m_sd;
        if (!st) begin
            w_valid = fwd_e; w_rd = m_rd; w_data = fd_e;
            if (m_valid && m_op == 2'b10) m_lc = m_lc + 16'd1;
            if (m_valid && m_op == 2'b11) m_sc = m_sc + 16'd1;
            m_valid = v && (op != 2'b00); m_op = op; m_rd = rd; m_res = res; m_sd = sd;
            m_written = 1'b0;
        end else if (we_e) begin
            m_written = 1'b1;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic bubble();
        cycle(1'b0, 2'b00, 3'd0, 16'd0, 16'd0, 1'b0);
    endtask

    task automatic test_reset();
        logic [15:0] v;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            v = (i == 2) ? 16'h0006 : 16'($urandom);
            pre_we = 1'b1; pre_addr = 8'(i); pre_data = v; ref_mem[i] = v;
            @(negedge clk);
        end
        pre_we = 1'b0;
        #1;
        checks++;
        if (dm_we !== 1'b0 || fwd_valid !== 1'b0 || load_use !== 1'b0 || wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: we=%b fwd=%b lu=%b wbv=%b required all 0",
                     dm_we, fwd_valid, load_use, wb_valid);
        end
        checks++;
        if (load_cnt !== 16'd0 || store_cnt !== 16'd0 || dm_addr !== 8'd0 || dm_wdata !== 16'd0) begin
            failures++;
            $display("FAIL reset_values: lc=%h sc=%h addr=%h wd=%h required 0",
                     load_cnt, store_cnt, dm_addr, dm_wdata);
        end
        rst = 1'b1;
        $display("reset: flags and counters checked");
    endtask

    task automatic test_alu();
        cycle(1'b1, 2'b01, 3'd3, 16'h1234, 16'hAAAA, 1'b0);
        checks++;
        if (dm_we !== 1'b0 || fwd_valid !== 1'b1 || fwd_rd !== 3'd3 || fwd_data !== 16'h1234) begin
            failures++;
            $display("FAIL alu_fwd: we=%b fv=%b rd=%0d data=%h required we=0 fv=1 rd=3 data=1234",
                     dm_we, fwd_valid, fwd_rd, fwd_data);
        end
        bubble();
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== 3'd3 || wb_data !== 16'h1234) begin
            failures++;
            $display("FAIL alu_wb: v=%b rd=%0d data=%h required v=1 rd=3 data=1234",
                     wb_valid, wb_rd, wb_data);
        end
        $display("alu: rd=3 data=%h wb_valid=%b", wb_data, wb_valid);
    endtask

    task automatic test_load();
        cycle(1'b1, 2'b10, 3'd5, 16'h0002, 16'h0000, 1'b0);
        checks++;
        if (load_use !== 1'b1 || fwd_data !== 16'h0006 || dm_addr !== 8'h02) begin
            failures++;
            $display("FAIL load_mem: lu=%b fwd=%h addr=%h required lu=1 fwd=0006 addr=02",
                     load_use, fwd_data, dm_addr);
        end
        bubble();
        checks++;
        if (load_use !== 1'b0 || wb_valid !== 1'b1 || wb_rd !== 3'd5 || wb_data !== 16'h0006 ||
            load_cnt !== 16'd1) begin
            failures++;
            $display("FAIL load_wb: lu=%b v=%b rd=%0d data=%h lc=%0d required lu=0 v=1 rd=5 data=0006 lc=1",
                     load_use, wb_valid, wb_rd, wb_data, load_cnt);
        end
        $display("load: addr=2 wb_data=%h load_cnt=%0d", wb_data, load_cnt);
    endtask

    task automatic test_store_stall();
        cycle(1'b1, 2'b11, 3'd0, 16'h0007, 16'hBEEF, 1'b0);
        we_seen = 0;
        checks++;
        if (dm_we !== 1'b1 || dm_addr !== 8'h07 || dm_wdata !== 16'hBEEF) begin
            failures++;
            $display("FAIL store_drive: we=%b addr=%h wd=%h required we=1 addr=07 wd=beef",
                     dm_we, dm_addr, dm_wdata);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 2'b01, 3'd1, 16'h5555, 16'h0000, 1'b1);
            checks++;
            if (dm_we !== 1'b0 || dm_addr !== 8'h07) begin
                failures++;
                $display("FAIL store_held: cycle=%0d we=%b addr=%h required we=0 addr=07",
                         i, dm_we, dm_addr);
            end
        end
        bubble();
        checks++;
        if (we_seen != 1 || tb_mem[7] !== 16'hBEEF || store_cnt !== 16'd1) begin
            failures++;
            $display("FAIL store_once: writes=%0d mem7=%h sc=%0d required writes=1 mem7=beef sc=1",
                     we_seen, tb_mem[7], store_cnt);
        end
        $display("store_stall: writes=%0d mem[7]=%h store_cnt=%0d", we_seen, tb_mem[7], store_cnt);
    endtask

    task automatic test_wrap();
        cycle(1'b1, 2'b10, 3'd2, 16'h0105, 16'h0000, 1'b0);
        checks++;
        if (dm_addr !== 8'h05 || fwd_data !== ref_mem[5]) begin
            failures++;
            $display("FAIL wrap_addr: addr=%h fwd=%h required addr=05 fwd=%h",
                     dm_addr, fwd_data, ref_mem[5]);
        end
        bubble();
        checks++;
        if (wb_data !== ref_mem[5] || wb_valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap_wb: data=%h v=%b required data=%h v=1", wb_data, wb_valid, ref_mem[5]);
        end
        $display("wrap: result=0105 addr=%h data=%h", dm_addr, wb_data);
    endtask

    task automatic test_back_to_back();
        logic [15:0] sd;
        sd = 16'($urandom);
        cycle(1'b1, 2'b11, 3'd0, 16'h0004, sd, 1'b0);
        cycle(1'b1, 2'b10, 3'd6, 16'h0004, 16'h0000, 1'b0);
        checks++;
        if (fwd_data !== sd || load_use !== 1'b1) begin
            failures++;
            $display("FAIL b2b_fwd: fwd=%h lu=%b required fwd=%h lu=1", fwd_data, load_use, sd);
        end
        bubble();
        checks++;
        if (wb_data !== sd || wb_rd !== 3'd6 || wb_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_wb: data=%h rd=%0d v=%b required data=%h rd=6 v=1",
                     wb_data, wb_rd, wb_valid, sd);
        end
        $display("back_to_back: stored=%h loaded=%h", sd, wb_data);
    endtask

    task automatic test_random();
        int errs;
        for (int n = 0; n < 300; n++) begin
            cycle(1'($urandom), 2'($urandom), 3'($urandom), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 3) == 0));
            errs = 0;
            checks++;
            if (dm_we !== exp_we() || dm_addr !== exp_addr() || dm_wdata !== exp_wdata()) begin
                errs++; failures++;
                $display("FAIL rand_mem: n=%0d we=%b addr=%h wd=%h required we=%b addr=%h wd=%h",
                         n, dm_we, dm_addr, dm_wdata, exp_we(), exp_addr(), exp_wdata());
            end
            checks++;
            if (fwd_valid !== exp_fwd() || load_use !== (m_valid && m_op == 2'b10) ||
                (exp_fwd() && (fwd_rd !== m_rd || fwd_data !== exp_fdata()))) begin
                errs++; failures++;
                $display("FAIL rand_fwd: n=%0d fv=%b lu=%b rd=%0d data=%h required fv=%b rd=%0d data=%h",
                         n, fwd_valid, load_use, fwd_rd, fwd_data, exp_fwd(), m_rd, exp_fdata());
            end
            checks++;
            if (wb_valid !== w_valid || (w_valid && (wb_rd !== w_rd || wb_data !== w_data))) begin
                errs++; failures++;
                $display("FAIL rand_wb: n=%0d v=%b rd=%0d data=%h required v=%b rd=%0d data=%h",
                         n, wb_valid, wb_rd, wb_data, w_valid, w_rd, w_data);
            end
            checks++;
            if (load_cnt !== m_lc || store_cnt !== m_sc) begin
                errs++; failures++;
                $display("FAIL rand_cnt: n=%0d lc=%0d sc=%0d required lc=%0d sc=%0d",
                         n, load_cnt, store_cnt, m_lc, m_sc);
            end
            $display("rand %0d: op=%0d stall=%b we=%b wbv=%b lc=%0d sc=%0d errs=%0d",
                     n, ex_op, stall, dm_we, wb_valid, load_cnt, store_cnt, errs);
        end
    endtask

    task automatic test_reset_mid_store();
        cycle(1'b1, 2'b10, 3'd4, 16'h0010, 16'h0000, 1'b0);
        cycle(1'b1, 2'b11, 3'd0, 16'h0020, 16'hCAFE, 1'b0);
        stall = 1'b1;
        checks++;
        if (dm_we !== 1'b1 || load_cnt === 16'd0) begin
            failures++;
            $display("FAIL rst_pre: we=%b lc=%0d required we=1 lc>0", dm_we, load_cnt);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (dm_we !== 1'b0 || wb_valid !== 1'b0 || load_cnt !== 16'd0 || store_cnt !== 16'd0 ||
            fwd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: we=%b wbv=%b lc=%0d sc=%0d fv=%b required all 0",
                     dm_we, wb_valid, load_cnt, store_cnt, fwd_valid);
        end
        model_clear();
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (dm_we !== 1'b0 || tb_mem[8'h20] !== ref_mem[8'h20]) begin
            failures++;
            $display("FAIL rst_after: we=%b mem20=%h required we=0 mem20=%h",
                     dm_we, tb_mem[8'h20], ref_mem[8'h20]);
        end
        $display("reset_mid_store: we=%b lc=%0d sc=%0d", dm_we, load_cnt, store_cnt);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store_stall();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_mid_store();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
